// File: rtl/jt12_snd_ser_pkg.sv
// rtl/jt12_snd_ser_pkg.sv - state encoding and frame-geometry helpers for the serial DAC output
//
// Purpose : shared between the RTL and its bench so both agree on the FSM
//           encoding and on how long one serial frame lasts.
// Contents: ser_state_t  - IDLE (no sample seen since reset) / RUN (clocks running)
//           frame_bits   - bits per stereo frame (two lrck half-frames)
//           frame_ticks  - clk_en ticks per stereo frame
package jt12_snd_ser_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ser_state_t;

   function automatic int frame_bits(input int wslot);
      return 2 * wslot;
   endfunction

   // One bit lasts two bck half-periods of bclk_div ticks each.
   function automatic int frame_ticks(input int wslot, input int bclk_div);
      return 4 * wslot * bclk_div;
   endfunction

endpackage

// File: rtl/jt12_snd_ser_clkgen.sv
// rtl/jt12_snd_ser_clkgen.sv - serial bit-clock divider with falling-edge strobe
//
// Purpose : divides clk_en ticks down to the DAC bit clock while the
//           serialiser is running; parked low with the divider cleared
//           otherwise.
// Ports   : i_clk     system clock
//           i_rst     synchronous active-high reset
//           i_clk_en  clock enable, nothing advances while low
//           i_run     serialiser is in RUN
//           o_bck     serial bit clock
//           o_fall    one-tick strobe on the tick where bck goes 1->0
module jt12_snd_ser_clkgen #(
   parameter int BCLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clk_en,
   input  logic i_run,
   output logic o_bck,
   output logic o_fall
);

   localparam int            DW       = $clog2(BCLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

   logic [DW-1:0] r_div;
   logic          r_bck;
   logic          w_wrap;

   assign w_wrap = i_clk_en & i_run & (r_div == DIV_LAST);
   assign o_fall = w_wrap & r_bck;
   assign o_bck  = r_bck;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div <= '0;
         r_bck <= 1'b0;
      end else if (i_clk_en) begin
         if (!i_run) begin
            r_div <= '0;
            r_bck <= 1'b0;
         end else if (w_wrap) begin
            r_div <= '0;
            r_bck <= ~r_bck;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

endmodule

// File: rtl/jt12_snd_ser.sv
// rtl/jt12_snd_ser.sv - left-justified serial DAC transmitter for the FM accumulator output
//
// Purpose : captures each stereo sample on the accumulator zero strobe into a
//           holding register and streams it MSB first, left slot then right
//           slot, each slot WSLOT bits with the sample left-justified. The
//           clocks never stop once started: with no fresh sample the last
//           frame is sent again.
// Ports   : i_clk     system clock
//           i_rst     synchronous active-high reset
//           i_clk_en  clock enable, all state (including o_ovr) holds while low
//           i_left    signed left sample, WIN bits
//           i_right   signed right sample, WIN bits
//           i_sample  i_left/i_right valid on this clk_en tick
//           o_bck     serial bit clock, DAC samples o_sd on its rising edge
//           o_lrck    0 = left slot, 1 = right slot
//           o_sd      serial data, MSB first
//           o_ovr     one-tick pulse: an unsent held sample was overwritten
module jt12_snd_ser
   import jt12_snd_ser_pkg::*;
#(
   parameter int WIN      = 12,
   parameter int WSLOT    = 16,
   parameter int BCLK_DIV = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clk_en,
   input  logic signed [WIN-1:0] i_left,
   input  logic signed [WIN-1:0] i_right,
   input  logic                  i_sample,
   output logic                  o_bck,
   output logic                  o_lrck,
   output logic                  o_sd,
   output logic                  o_ovr
);

   localparam int            FW       = frame_bits(WSLOT);
   localparam int            BW       = $clog2(FW);
   localparam int            PAD      = WSLOT - WIN;
   localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
   localparam logic [BW-1:0] BIT_HALF = BW'(WSLOT - 1);

   // Left-justify one sample inside its slot; low PAD bits are zero.
   function automatic logic [WSLOT-1:0] to_slot(input logic [WIN-1:0] x);
      logic [WSLOT-1:0] t;
      t = WSLOT'(x);
      return t << PAD;
   endfunction

   ser_state_t     r_state;
   ser_state_t     w_state_nx;

   logic [WIN-1:0] r_hold_l;
   logic [WIN-1:0] r_hold_r;
   logic           r_hold_v;
   logic [FW-1:0]  r_shift;
   logic [FW-1:0]  r_frame;     // last frame loaded, resent when nothing new arrives
   logic [BW-1:0]  r_bit;
   logic           r_lrck;
   logic           r_sd;
   logic           r_ovr;

   logic           w_fall;
   logic           w_frame_end;
   logic           w_load;
   logic           w_bypass;
   logic [FW-1:0]  w_word;

   jt12_snd_ser_clkgen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_clkgen (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clk_en (i_clk_en),
      .i_run    (r_state == ST_RUN),
      .o_bck    (o_bck),
      .o_fall   (w_fall)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and frame-load decisions
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nx  = r_state;
      w_load      = 1'b0;
      w_bypass    = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_clk_en && r_hold_v) begin
               w_load     = 1'b1;
               w_state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            // w_fall is already qualified by clk_en inside the clock generator.
            w_frame_end = w_fall && (r_bit == BIT_LAST);
            if (w_frame_end) begin
               w_load = 1'b1;
               // A strobe landing on the frame boundary goes straight into the
               // new frame instead of waiting a whole frame in the hold buffer.
               w_bypass = i_sample;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Frame source for a load: fresh inputs, then the hold buffer, then a repeat.
   always_comb begin
      w_word = r_frame;
      if (w_bypass) begin
         w_word = {to_slot(i_left), to_slot(i_right)};
      end else if (r_hold_v) begin
         w_word = {to_slot(r_hold_l), to_slot(r_hold_r)};
      end
   end

   // ------------------------------------------------------------------
   // Hold buffer, shifter and slot tracking
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_l <= '0;
         r_hold_r <= '0;
         r_hold_v <= 1'b0;
         r_shift  <= '0;
         r_frame  <= '0;
         r_bit    <= '0;
         r_lrck   <= 1'b0;
         r_sd     <= 1'b0;
         r_ovr    <= 1'b0;
      end else if (i_clk_en) begin
         // Overrun only when the pending sample is neither consumed by a load
         // nor bypassed on this tick.
         r_ovr <= i_sample & r_hold_v & ~w_load;

         if (w_bypass) begin
            r_hold_v <= 1'b0;
         end else if (i_sample) begin
            // In IDLE a load and a new strobe can coincide: the load takes the
            // old held sample and the new one waits in the buffer.
            r_hold_l <= i_left;
            r_hold_r <= i_right;
            r_hold_v <= 1'b1;
         end else if (w_load) begin
            r_hold_v <= 1'b0;
         end

         if (w_load) begin
            r_shift <= w_word;
            r_frame <= w_word;
            r_sd    <= w_word[FW-1];
            r_bit   <= '0;
            r_lrck  <= 1'b0;
         end else if (w_fall) begin
            // sd and lrck move together on the falling edge so both are stable
            // at the following rising edge.
            r_shift <= r_shift << 1;
            r_sd    <= r_shift[FW-2];
            r_bit   <= r_bit + 1'b1;
            if (r_bit == BIT_HALF) begin
               r_lrck <= 1'b1;
            end
         end
      end
   end

   assign o_lrck = r_lrck;
   assign o_sd   = r_sd;
   assign o_ovr  = r_ovr;

endmodule

// File: tb/tb_jt12_snd_ser.sv
// tb/tb_jt12_snd_ser.sv - self-checking bench for jt12_snd_ser
`timescale 1ns/1ps
module tb_jt12_snd_ser;
   import jt12_snd_ser_pkg::*;

   localparam int WIN   = 12;
   localparam int WSLOT = 16;
   localparam int BDIV  = 2;
   localparam int FT    = frame_ticks(WSLOT, BDIV);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            clk_en = 1'b1;
   logic            sample = 1'b0;
   logic [WIN-1:0]  left = '0;
   logic [WIN-1:0]  right = '0;
   logic            bck, lrck, sd, ovr;

   int errs = 0;
   int checks = 0;

   jt12_snd_ser #(
      .WIN      (WIN),
      .WSLOT    (WSLOT),
      .BCLK_DIV (BDIV)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_clk_en (clk_en),
      .i_left   (left),
      .i_right  (right),
      .i_sample (sample),
      .o_bck    (bck),
      .o_lrck   (lrck),
      .o_sd     (sd),
      .o_ovr    (ovr)
   );

   always #5 clk = ~clk;

   // Expected serial frame: each sample left-justified in a 16-bit slot.
   function automatic logic [31:0] mk(input logic [11:0] l, input logic [11:0] r);
      return {l, 4'h0, r, 4'h0};
   endfunction

   // ---------------- stimulus log and tick counter ----------------
   int          tick = 0;
   int          log_tick[$];
   logic [31:0] log_word[$];

   always @(posedge clk) begin
      if (clk_en) begin
         tick++;
         if (sample && !rst) begin
            log_tick.push_back(tick);
            log_word.push_back(mk(left, right));
         end
      end
   end

   // ---------------- serial decoder (DAC side) ----------------
   logic [31:0] q_word[$];
   int          q_tick[$];
   bit          q_lrbad[$];
   int          ovr_cnt = 0;
   logic [31:0] mon_word = '0;
   int          mon_bits = 0;
   bit          mon_lrbad = 1'b0;
   logic        mon_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         mon_bits  = 0;
         mon_lrbad = 1'b0;
         mon_prev  = 1'b0;
      end else begin
         if (bck === 1'b1 && mon_prev === 1'b0) begin
            mon_word = {mon_word[30:0], sd};
            if (lrck !== ((mon_bits >= WSLOT) ? 1'b1 : 1'b0)) mon_lrbad = 1'b1;
            mon_bits++;
            if (mon_bits == 2 * WSLOT) begin
               q_word.push_back(mon_word);
               q_tick.push_back(tick);
               q_lrbad.push_back(mon_lrbad);
               mon_bits  = 0;
               mon_lrbad = 1'b0;
            end
         end
         mon_prev = bck;
         if (ovr === 1'b1) ovr_cnt++;
      end
   end

   // Reference: a frame carries the newest sample strobed no later than the
   // tick that started it; that tick is one frame minus half a bit before the
   // frame's last rising bck.
   function automatic logic [31:0] model_frame(input int n_c);
      int          n_l;
      logic [31:0] w;
      n_l = n_c - FT + BDIV;
      w   = 'x;
      for (int i = 0; i < log_tick.size(); i++)
         if (log_tick[i] <= n_l) w = log_word[i];
      return w;
   endfunction

   // ---------------- driving helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic strobe(input logic [11:0] l, input logic [11:0] r);
      left   = l;
      right  = r;
      sample = 1'b1;
      cyc();
      sample = 1'b0;
   endtask

   task automatic wait_frames(input int k, input int budget);
      int n = 0;
      while (q_word.size() < k && n < budget) begin
         cyc();
         n++;
      end
   endtask

   task automatic clear_frames();
      q_word.delete();
      q_tick.delete();
      q_lrbad.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; clk_en = 1'b1; sample = 1'b0;
      repeat (3) cyc();
      checks++; if (bck !== 1'b0)  begin errs++; $display("FAIL reset_bck: got %b expected 0", bck); end
      checks++; if (lrck !== 1'b0) begin errs++; $display("FAIL reset_lrck: got %b expected 0", lrck); end
      checks++; if (sd !== 1'b0)   begin errs++; $display("FAIL reset_sd: got %b expected 0", sd); end
      checks++; if (ovr !== 1'b0)  begin errs++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
      rst = 1'b0;
   endtask

   task automatic test_idle();
      bit bad = 1'b0;
      int ov0 = ovr_cnt;
      repeat (500) begin
         cyc();
         if (bck !== 1'b0 || lrck !== 1'b0 || sd !== 1'b0 || ovr !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errs++; $display("FAIL idle_outputs: got activity expected bck=lrck=sd=ovr=0"); end
      checks++; if (ovr_cnt != ov0) begin errs++; $display("FAIL idle_ovr: got %0d pulses expected 0", ovr_cnt - ov0); end
   endtask

   task automatic test_single();
      int ts;
      clear_frames();
      strobe(12'h5A3, 12'hA5C);
      ts = tick;
      wait_frames(3, 4 * FT);
      checks++;
      if (q_word.size() < 3) begin
         errs++; $display("FAIL single_frames: got %0d frames expected 3", q_word.size());
      end else begin
         checks++; if (q_tick[0] != ts + 1 + FT - BDIV) begin errs++; $display("FAIL single_latency: frame end tick %0d expected %0d", q_tick[0], ts + 1 + FT - BDIV); end
         for (int i = 0; i < 3; i++) begin
            checks++; if (q_word[i] !== 32'h5A30A5C0) begin errs++; $display("FAIL single_word[%0d]: got %h expected 5a30a5c0", i, q_word[i]); end
            checks++; if (q_lrbad[i]) begin errs++; $display("FAIL single_lrck[%0d]: got lrck misplaced expected rise after 16 bck", i); end
            if (i > 0) begin
               checks++; if (q_tick[i] - q_tick[i-1] != FT) begin errs++; $display("FAIL single_gap[%0d]: got %0d ticks expected %0d", i, q_tick[i] - q_tick[i-1], FT); end
            end
         end
      end
   endtask

   task automatic check_stream(input string name, input logic [31:0] exp[$], input int ov0);
      for (int i = 0; i < q_word.size(); i++) begin
         logic [31:0] m;
         m = model_frame(q_tick[i]);
         checks++; if (q_word[i] !== m || q_lrbad[i]) begin errs++; $display("FAIL %s_frame[%0d]: got %h lrbad=%0d expected %h lrbad=0", name, i, q_word[i], q_lrbad[i], m); end
      end
      foreach (exp[k]) begin
         bit seen = 1'b0;
         foreach (q_word[i]) if (q_word[i] === exp[k]) seen = 1'b1;
         checks++; if (!seen) begin errs++; $display("FAIL %s_skip[%0d]: got no frame with %h expected one", name, k, exp[k]); end
      end
      checks++; if (ovr_cnt != ov0) begin errs++; $display("FAIL %s_ovr: got %0d pulses expected 0", name, ovr_cnt - ov0); end
   endtask

   task automatic test_stream();
      logic [31:0] exp[$];
      int ov0 = ovr_cnt;
      clear_frames();
      for (int n = 1; n <= 20; n++) begin
         strobe(12'(n), 12'(-n));
         exp.push_back(mk(12'(n), 12'(-n)));
         repeat (143) cyc();
      end
      repeat (2 * FT) cyc();
      check_stream("stream", exp, ov0);
   endtask

   task automatic test_random();
      logic [31:0] exp[$];
      int ov0 = ovr_cnt;
      clear_frames();
      repeat (10) begin
         logic [11:0] l, r;
         int gap;
         l = 12'($urandom);
         r = 12'($urandom);
         strobe(l, r);
         exp.push_back(mk(l, r));
         gap = $urandom_range(FT, 2 * FT);
         repeat (gap - 1) cyc();
      end
      repeat (2 * FT) cyc();
      check_stream("random", exp, ov0);
   endtask

   task automatic test_overrun();
      int ov0;
      clear_frames();
      wait_frames(1, 2 * FT);
      ov0 = ovr_cnt;
      repeat (20) cyc();
      strobe(12'h111, 12'h111);
      repeat (9) cyc();
      strobe(12'h222, 12'h222);
      wait_frames(3, 3 * FT);
      checks++; if (ovr_cnt - ov0 != 1) begin errs++; $display("FAIL overrun_pulse: got %0d ticks expected 1", ovr_cnt - ov0); end
      checks++;
      if (q_word.size() < 3) begin
         errs++; $display("FAIL overrun_frames: got %0d frames expected 3", q_word.size());
      end else begin
         checks++; if (q_word[1] !== model_frame(q_tick[1])) begin errs++; $display("FAIL overrun_prev: got %h expected %h", q_word[1], model_frame(q_tick[1])); end
         checks++; if (q_word[2] !== 32'h22202220) begin errs++; $display("FAIL overrun_next: got %h expected 22202220", q_word[2]); end
      end
   endtask

   task automatic test_bypass();
      int ov0, idx, n, target, qs;
      clear_frames();
      strobe(12'h800, 12'h000);
      idx = -1; n = 0;
      while (idx < 0 && n < 4 * FT) begin
         cyc(); n++;
         if (q_word.size() > 0 && q_word[q_word.size()-1] === mk(12'h800, 12'h000)) idx = q_word.size() - 1;
      end
      checks++;
      if (idx < 0) begin
         errs++; $display("FAIL bypass_setup: got no 80000000 frame expected one");
      end else begin
         target = q_tick[idx] + BDIV + FT;
         n = 0;
         while (tick < target - 1 && n < 2 * FT) begin cyc(); n++; end
         checks++; if (tick != target - 1) begin errs++; $display("FAIL bypass_align: got tick %0d expected %0d", tick, target - 1); end
         ov0 = ovr_cnt;
         strobe(12'h7FF, 12'h123);
         checks++; if (sd !== 1'b0) begin errs++; $display("FAIL bypass_msb: got sd=%b expected 0", sd); end
         qs = q_word.size();
         wait_frames(qs + 2, 3 * FT);
         checks++; if (ovr_cnt != ov0) begin errs++; $display("FAIL bypass_ovr: got %0d pulses expected 0", ovr_cnt - ov0); end
         checks++;
         if (q_word.size() < qs + 2) begin
            errs++; $display("FAIL bypass_frames: got %0d frames expected %0d", q_word.size(), qs + 2);
         end else begin
            checks++; if (q_word[qs] !== 32'h7FF01230) begin errs++; $display("FAIL bypass_word: got %h expected 7ff01230", q_word[qs]); end
            checks++; if (q_word[qs+1] !== 32'h7FF01230) begin errs++; $display("FAIL bypass_repeat: got %h expected 7ff01230", q_word[qs+1]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      while (lrck !== 1'b1 && n < 2 * FT) begin cyc(); n++; end
      checks++; if (lrck !== 1'b1) begin errs++; $display("FAIL rstmid_slot: got lrck=%b expected 1", lrck); end
      repeat (3) cyc();
      rst = 1'b1;
      cyc();
      checks++; if ({bck, lrck, sd, ovr} !== 4'b0000) begin errs++; $display("FAIL rstmid_outputs: got %b expected 0000", {bck, lrck, sd, ovr}); end
      rst = 1'b0;
      log_tick.delete(); log_word.delete();
      clear_frames();
      repeat (20) cyc();
      checks++; if ({bck, lrck, sd, ovr} !== 4'b0000) begin errs++; $display("FAIL rstmid_idle: got %b expected 0000", {bck, lrck, sd, ovr}); end
      strobe(12'h9C4, 12'h3B1);
      checks++; if (sd !== 1'b0) begin errs++; $display("FAIL rstmid_early: got sd=%b expected 0", sd); end
      cyc();
      checks++; if (sd !== 1'b1 || lrck !== 1'b0) begin errs++; $display("FAIL rstmid_latency: got sd=%b lrck=%b expected sd=1 lrck=0", sd, lrck); end
      wait_frames(1, 2 * FT);
      checks++;
      if (q_word.size() < 1) begin
         errs++; $display("FAIL rstmid_frames: got 0 frames expected 1");
      end else begin
         checks++; if (q_word[0] !== 32'h9C403B10 || q_lrbad[0]) begin errs++; $display("FAIL rstmid_word: got %h lrbad=%0d expected 9c403b10 lrbad=0", q_word[0], q_lrbad[0]); end
      end
   endtask

   task automatic test_clk_en();
      int ts = 0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      log_tick.delete(); log_word.delete();
      clear_frames();
      for (int c = 0; c < 9 * FT + 60 && q_word.size() < 2; c++) begin
         clk_en = (c % 3 == 0);
         sample = (c == 3);
         left   = 12'h5A3;
         right  = 12'hA5C;
         cyc();
         if (c == 3) ts = tick;
      end
      clk_en = 1'b1;
      sample = 1'b0;
      checks++;
      if (q_word.size() < 2) begin
         errs++; $display("FAIL clken_frames: got %0d frames expected 2", q_word.size());
      end else begin
         checks++; if (q_tick[0] != ts + 1 + FT - BDIV) begin errs++; $display("FAIL clken_latency: frame end tick %0d expected %0d", q_tick[0], ts + 1 + FT - BDIV); end
         for (int i = 0; i < 2; i++) begin
            checks++; if (q_word[i] !== 32'h5A30A5C0 || q_lrbad[i]) begin errs++; $display("FAIL clken_word[%0d]: got %h lrbad=%0d expected 5a30a5c0 lrbad=0", i, q_word[i], q_lrbad[i]); end
         end
         checks++; if (q_tick[1] - q_tick[0] != FT) begin errs++; $display("FAIL clken_gap: got %0d ticks expected %0d", q_tick[1] - q_tick[0], FT); end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_stream();
      test_random();
      test_overrun();
      test_bypass();
      test_reset_mid();
      test_clk_en();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

endmodule
